blue_motion: RTL and testbench

Per-frame position controller for the blue character sprite (23×45 px) on the 640×480 playfield. Each frame it converts key inputs into motion: walking, jump, gravity. It moves the sprite one pixel at a time and consumes the registered 4-bit collision flags from the collision stage after every pixel. The collision stage matches edge positions by exact equality, so single-pixel stepping is mandatory. The block produces `x_blue`/`y_blue`, which drive both the collision stage and the sprite renderer.

---
 rtl/blue_pkg.sv | 39 +++
 rtl/blue_motion_if.sv | 23 ++
 rtl/blue_air_fsm.sv | 102 ++++++++++
 rtl/blue_motion.sv | 141 ++++++++++++++
 tb/tb_blue_motion.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/blue_pkg.sv
// blue_motion shared types and constants: air/sequencer states,
// sprite and screen geometry, collision flag bit positions.
package blue_pkg;

  localparam int SPR_W = 23;
  localparam int SPR_H = 45;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  localparam logic [9:0] X_INIT = 10'd40;
  localparam logic [8:0] Y_INIT = 9'd390;
  localparam logic [9:0] X_MAX  = 10'(SCR_W - SPR_W);
  localparam logic [8:0] Y_MAX  = 9'(SCR_H - SPR_H);

  localparam logic [3:0] STEP_X  = 4'd2;
  localparam logic [3:0] JUMP_V  = 4'd8;
  localparam logic [3:0] GRAVITY = 4'd1;
  localparam logic [3:0] VMAX    = 4'd8;
  localparam logic [1:0] SETTLE  = 2'd2;

  localparam int COLL_DOWN  = 0;
  localparam int COLL_UP    = 1;
  localparam int COLL_RIGHT = 2;
  localparam int COLL_LEFT  = 3;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } air_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2,
    S_WAIT   = 2'd3
  } seq_e;

endpackage

// File: rtl/blue_motion_if.sv
// blue_motion frame/key/collision inputs and position/status outputs.
// master: drives tick, keys, flags; slave: the motion block.
interface blue_motion_if;
  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [3:0] is_collision;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [1:0] air_state;
  logic       busy;

  modport master (
    output frame_tick, key_left, key_right, key_jump, is_collision,
    input  x_blue, y_blue, air_state, busy
  );

  modport slave (
    input  frame_tick, key_left, key_right, key_jump, is_collision,
    output x_blue, y_blue, air_state, busy
  );
endinterface

// File: rtl/blue_air_fsm.sv
// Air state, vertical speed, jump edge and optional air-jump counter.
// Ports: tick/hit/frame_end strobes in; air, vy out. Macro BLUE_DOUBLE_JUMP_EN.
module blue_air_fsm
  import blue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_jump,
  input  logic       coll_down,
  input  logic       y_at_max,
  input  logic       hit,
  input  logic       frame_end,
  output air_e       air,
  output logic [3:0] vy
);
  air_e       air_q, air_d;
  logic [3:0] vy_q, vy_d;
  logic       jprev_q, jprev_d;
  logic       jedge;

  assign jedge = key_jump && !jprev_q;

`ifdef BLUE_DOUBLE_JUMP_EN
  logic cnt_q, cnt_d;
`endif

  always_comb begin
    air_d   = air_q;
    vy_d    = vy_q;
    jprev_d = jprev_q;
`ifdef BLUE_DOUBLE_JUMP_EN
    cnt_d   = cnt_q;
`endif
    if (tick) begin
      jprev_d = key_jump;
      if (air_q == GROUNDED) begin
        if (jedge) begin
          air_d = RISING;
          vy_d  = JUMP_V;
        end else if (!coll_down && !y_at_max) begin
          air_d = FALLING;
          vy_d  = GRAVITY;
        end
      end
`ifdef BLUE_DOUBLE_JUMP_EN
      else if (jedge && !cnt_q) begin
        air_d = RISING;
        vy_d  = JUMP_V;
        cnt_d = 1'b1;
      end
`endif
    end else if (hit) begin
      vy_d = '0;
      if (air_q == RISING) begin
        air_d = FALLING;
      end else begin
        air_d = GROUNDED;
`ifdef BLUE_DOUBLE_JUMP_EN
        cnt_d = 1'b0;
`endif
      end
    end else if (frame_end) begin
      unique case (air_q)
        RISING: begin
          if (vy_q <= GRAVITY) begin
            air_d = FALLING;
            vy_d  = '0;
          end else begin
            vy_d = vy_q - GRAVITY;
          end
        end
        FALLING: begin
          vy_d = (vy_q > VMAX - GRAVITY) ? VMAX : vy_q + GRAVITY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      air_q   <= FALLING;
      vy_q    <= '0;
      jprev_q <= 1'b0;
`ifdef BLUE_DOUBLE_JUMP_EN
      cnt_q   <= 1'b0;
`endif
    end else begin
      air_q   <= air_d;
      vy_q    <= vy_d;
      jprev_q <= jprev_d;
`ifdef BLUE_DOUBLE_JUMP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign air = air_q;
  assign vy  = vy_q;

endmodule

// File: rtl/blue_motion.sv
// Per-frame sprite position sequencer: single-pixel x then y steps,
// collision-checked each pixel. Ports: clk, rst_n, bus (slave).
module blue_motion
  import blue_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  blue_motion_if.slave bus
);
  seq_e       state_q, state_d, ret_q, ret_d;
  logic [1:0] wait_q, wait_d;
  logic [3:0] xbud_q, xbud_d, ybud_q, ybud_d;
  logic       yld_q, yld_d, right_q, right_d, busy_q, busy_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       tick, hit, frame_end, up;
  logic       x_blk, x_bnd, y_blk, y_bnd;
  logic [3:0] vy;
  air_e       air;

  assign tick  = bus.frame_tick && (state_q == S_IDLE);
  assign up    = (air == RISING);
  assign x_blk = right_q ? bus.is_collision[COLL_RIGHT]
                         : bus.is_collision[COLL_LEFT];
  assign x_bnd = right_q ? (x_q >= X_MAX) : (x_q == '0);
  assign y_blk = up ? bus.is_collision[COLL_UP]
                    : bus.is_collision[COLL_DOWN];
  assign y_bnd = up ? (y_q == '0) : (y_q >= Y_MAX);

  blue_air_fsm u_air (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .key_jump  (bus.key_jump),
    .coll_down (bus.is_collision[COLL_DOWN]),
    .y_at_max  (y_q >= Y_MAX),
    .hit       (hit),
    .frame_end (frame_end),
    .air       (air),
    .vy        (vy)
  );

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    wait_d    = wait_q;
    xbud_d    = xbud_q;
    ybud_d    = ybud_q;
    yld_d     = yld_q;
    right_d   = right_q;
    busy_d    = busy_q;
    x_d       = x_q;
    y_d       = y_q;
    hit       = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_tick) begin
          state_d = S_MOVE_X;
          busy_d  = 1'b1;
          yld_d   = 1'b1;
          right_d = bus.key_right;
          xbud_d  = (bus.key_left ^ bus.key_right) ? STEP_X : '0;
        end
      end
      S_MOVE_X: begin
        if (xbud_q == '0) begin
          state_d = S_MOVE_Y;
        end else if (x_blk || x_bnd) begin
          xbud_d = '0;
        end else begin
          x_d     = right_q ? x_q + 10'd1 : x_q - 10'd1;
          xbud_d  = xbud_q - 4'd1;
          ret_d   = S_MOVE_X;
          wait_d  = SETTLE;
          state_d = S_WAIT;
        end
      end
      S_MOVE_Y: begin
        // first visit latches vy, settled since the tick
        if (yld_q) begin
          ybud_d = vy;
          yld_d  = 1'b0;
        end else if (ybud_q == '0) begin
          frame_end = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (y_blk || y_bnd) begin
          // bump/landing ends the frame; its vy=0 holds next frame
          hit     = 1'b1;
          ybud_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          y_d     = up ? y_q - 9'd1 : y_q + 9'd1;
          ybud_d  = ybud_q - 4'd1;
          ret_d   = S_MOVE_Y;
          wait_d  = SETTLE;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 2'd1;
        if (wait_q <= 2'd1) state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_MOVE_X;
      wait_q  <= '0;
      xbud_q  <= '0;
      ybud_q  <= '0;
      yld_q   <= 1'b0;
      right_q <= 1'b0;
      busy_q  <= 1'b0;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      xbud_q  <= xbud_d;
      ybud_q  <= ybud_d;
      yld_q   <= yld_d;
      right_q <= right_d;
      busy_q  <= busy_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.x_blue    = x_q;
  assign bus.y_blue    = y_q;
  assign bus.air_state = air;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_blue_motion.sv
// Scoreboard bench for blue_motion: per-frame model predicts x/y/air,
// compared when busy falls; plus directed boundary checks.
module tb_blue_motion;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  blue_motion_if bus();

  blue_motion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int air;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int mx, my, mair, mvy, mprev, mcnt;
  int last_busy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 40; my = 390; mair = 2; mvy = 0; mprev = 0; mcnt = 0;
    sb.delete();
  endtask

  task automatic model_frame(input bit l, input bit r, input bit j,
                             input logic [3:0] f);
    int hb, vb;
    bit edg, up, hit;
    exp_t e;
    hb = (l ^ r) ? 2 : 0;
    edg = j && (mprev == 0);
    mprev = j;
    if (mair == 0) begin
      if (edg) begin mair = 1; mvy = 8; end
      else if (!f[0] && my < 435) begin mair = 2; mvy = 1; end
    end
`ifdef BLUE_DOUBLE_JUMP_EN
    else if (edg && mcnt == 0) begin mair = 1; mvy = 8; mcnt = 1; end
`endif
    for (int i = 0; i < hb; i++) begin
      if (r ? f[2] : f[3]) break;
      if (r ? (mx == 617) : (mx == 0)) break;
      mx = r ? mx + 1 : mx - 1;
    end
    up = (mair == 1);
    hit = 0;
    vb = mvy;
    for (int i = 0; i < vb; i++) begin
      if (up ? f[1] : f[0]) hit = 1;
      else if (up ? (my == 0) : (my == 435)) hit = 1;
      if (hit) break;
      my = up ? my - 1 : my + 1;
    end
    if (hit) begin
      mvy = 0;
      if (up) mair = 2;
      else begin mair = 0; mcnt = 0; end
    end else if (mair == 1) begin
      if (mvy <= 1) begin mair = 2; mvy = 0; end
      else mvy = mvy - 1;
    end else if (mair == 2) begin
      mvy = (mvy + 1 > 8) ? 8 : mvy + 1;
    end
    e.x = mx; e.y = my; e.air = mair;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input bit extra);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      bus.frame_tick = extra && (n == 3);
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    last_busy = n;
    chk("busy_fall", bus.busy, 1'b0);
  endtask

  task automatic run_frame(input bit l, input bit r, input bit j,
                           input logic [3:0] f, input bit extra);
    exp_t e;
    @(negedge clk);
    bus.key_left = l;
    bus.key_right = r;
    bus.key_jump = j;
    bus.is_collision = f;
    bus.frame_tick = 1'b1;
    model_frame(l, r, j, f);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    chk("busy_rise", bus.busy, 1'b1);
    wait_idle(extra);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("x", bus.x_blue, e.x);
      chk("y", bus.y_blue, e.y);
      chk("air", bus.air_state, e.air);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    bus.frame_tick = 1'b0;
    bus.key_left = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump = 1'b0;
    bus.is_collision = 4'b0001;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_x", bus.x_blue, 40);
    chk("rst_y", bus.y_blue, 390);
    chk("rst_air", bus.air_state, 2);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // settle onto the floor, then walk right
    run_frame(0, 0, 0, 4'b0001, 0);
    run_frame(0, 0, 0, 4'b0001, 0);
    chk("landed", bus.air_state, 0);
    run_frame(0, 1, 0, 4'b0001, 0);
    chk("walk_busy", last_busy, 9);
    chk("walk_x", bus.x_blue, 42);
    chk("walk_y", bus.y_blue, 390);
    run_frame(1, 0, 0, 4'b0001, 0);
    run_frame(1, 1, 0, 4'b0001, 0);
    run_frame(0, 1, 0, 4'b0101, 0);
    run_frame(1, 0, 0, 4'b1001, 0);
    run_frame(0, 1, 0, 4'b0001, 1);

    // jump arc
    for (int i = 0; i < 8; i++) run_frame(0, 0, 1, 4'b0000, 0);
    chk("arc_y", bus.y_blue, 354);
    chk("arc_air", bus.air_state, 2);
    n = 0;
    while (mair != 0 && n < 40) begin
      run_frame(0, 0, 0, 4'b0000, 0);
      n++;
    end
    chk("floor_y", bus.y_blue, 435);
    chk("floor_air", bus.air_state, 0);

    // air jump attempt while falling, then a third edge
    run_frame(0, 0, 1, 4'b0000, 0);
    for (int i = 0; i < 9; i++) run_frame(0, 0, 0, 4'b0000, 0);
    run_frame(0, 0, 1, 4'b0000, 0);
`ifdef BLUE_DOUBLE_JUMP_EN
    chk("air_jump", bus.air_state, 1);
`else
    chk("air_jump", bus.air_state, 2);
`endif
    run_frame(0, 0, 0, 4'b0000, 0);
    run_frame(0, 0, 1, 4'b0000, 0);
    n = 0;
    while (mair != 0 && n < 60) begin
      run_frame(0, 0, 0, 4'b0000, 0);
      n++;
    end
    chk("floor2_y", bus.y_blue, 435);

    // head bump after three pixels
    @(negedge clk);
    bus.key_jump = 1'b1;
    bus.is_collision = 4'b0000;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    n = 0;
    while (bus.y_blue !== 9'd432 && n < 100) begin
      n++;
      @(negedge clk);
    end
    bus.is_collision = 4'b0010;
    wait_idle(0);
    chk("bump_y", bus.y_blue, 432);
    chk("bump_air", bus.air_state, 2);
    my = 432; mair = 2; mvy = 0; mprev = 1;
    run_frame(0, 0, 1, 4'b0000, 0);
    chk("bump_next_y", bus.y_blue, 432);
    n = 0;
    while (mair != 0 && n < 40) begin
      run_frame(0, 0, 0, 4'b0000, 0);
      n++;
    end

    // walk into both horizontal limits
    n = 0;
    while (mx < 617 && n < 400) begin
      run_frame(0, 1, 0, 4'b0000, 0);
      n++;
    end
    run_frame(0, 1, 0, 4'b0000, 0);
    chk("clamp_r", bus.x_blue, 617);
    n = 0;
    while (mx > 0 && n < 400) begin
      run_frame(1, 0, 0, 4'b0000, 0);
      n++;
    end
    run_frame(1, 0, 0, 4'b0000, 0);
    chk("clamp_l", bus.x_blue, 0);

    // reset in the middle of a frame
    @(negedge clk);
    bus.key_right = 1'b1;
    bus.key_left = 1'b0;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_x", bus.x_blue, 40);
    chk("mid_rst_y", bus.y_blue, 390);
    chk("mid_rst_air", bus.air_state, 2);
    chk("mid_rst_busy", bus.busy, 0);
    model_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
